design_sel_ctrl: RTL and testbench
==================================

DESIGN_SEL_CTRL -- requirements
Module: design_sel_ctrl

Interface
REQ-001 SHALL have parameter SEL_BITS, default 5, giving the width of the design index.
REQ-002 SHALL have parameter NUM_DESIGNS, default 32, giving the number of valid design indices (0..NUM_DESIGNS-1).
REQ-003 SHALL have parameter RST_CYCLES, default 8, range 1..255, giving the length of each reset phase in cycles.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: a design-switch request is present.
REQ-007 SHALL have port req_sel, input, SEL_BITS bits: the requested design index.
REQ-008 SHALL have port req_ready, output, 1 bit: a request can be accepted this cycle.
REQ-009 SHALL have port user_rst_n, input, 1 bit: the user reset for the active design, active-low.
REQ-010 SHALL have port sel_out, output, SEL_BITS bits: the registered design index that drives the mux sel.
REQ-011 SHALL have port rst_n_out, output, 1 bit: the registered reset that drives the mux rst_n.
REQ-012 SHALL have port active, output, 1 bit: the selected design is running (state RUN).

Function
REQ-013 SHALL implement a state machine with states DRAIN, SWITCH, HOLD and RUN; all outputs SHALL be registered.
REQ-014 SHALL drive req_ready=1 and active=1 only in RUN.
- A request is accepted when req_valid and req_ready are both 1 on the same edge.
- A pending request SHALL NOT be latched while req_ready=0.
REQ-015 In RUN, rst_n_out SHALL equal user_rst_n delayed by one cycle; sel_out SHALL hold its value.
REQ-016 On acceptance, SHALL capture req_sel, enter DRAIN and drive rst_n_out=0 from the next cycle.
REQ-017 SHALL remain in DRAIN for exactly RST_CYCLES cycles with the old sel_out held, then enter SWITCH.
REQ-018 SWITCH SHALL last one cycle; sel_out SHALL take the captured index in that cycle and rst_n_out SHALL stay 0.
REQ-019 SHALL remain in HOLD for exactly RST_CYCLES cycles with rst_n_out=0, then enter RUN.
REQ-020 The timing of a switch, with acceptance in cycle T and R=RST_CYCLES, SHALL be:
- rst_n_out=0 from T+1;
- new sel_out from T+R+1;
- RUN from T+2R+2.
REQ-021 A request whose req_sel equals the current sel_out SHALL run the full DRAIN/SWITCH/HOLD sequence, which acts as a re-reset of that design.
REQ-022 SHALL ignore user_rst_n in DRAIN, SWITCH and HOLD.
REQ-023 The phase counter SHALL be 8 bits wide, SHALL count down to zero, and SHALL NOT wrap.

Reset
REQ-024 While rst=1, SHALL force state=HOLD, load the counter with RST_CYCLES, and drive sel_out=0, rst_n_out=0, req_ready=0 and active=0.
REQ-025 The first RUN cycle SHALL occur RST_CYCLES cycles after the first cycle with rst=0, with design 0 selected.
REQ-026 rst asserted in any state, including mid-switch, SHALL abort the sequence at the next edge and discard the captured index; sel_out SHALL return to 0.

Configuration
REQ-027 Macro DSC_RANGE_CHECK_EN SHALL control range checking of requests.
- Defined: a request with req_sel >= NUM_DESIGNS is accepted (req_ready handshake completes) but dropped; state, sel_out and rst_n_out are unchanged; output port err (1 bit) pulses high for exactly one cycle after acceptance; err resets to 0.
- Undefined: no err port; out-of-range indices are sequenced like any other index, and sel_out takes the out-of-range value.

Verification
REQ-028 Reset: RST_CYCLES=4, rst high 3 cycles then low -> sel_out=0 and rst_n_out=0 throughout; active=1 and req_ready=1 first in cycle 4 after release.
REQ-029 Switch: in RUN with sel_out=0, accept req_sel=5 at cycle 10 with R=4 -> rst_n_out=0 at 11; sel_out=0 through 14 and 5 at 15; active=1 at 20.
REQ-030 Backpressure: req_valid=1 with req_sel=7 held during DRAIN -> req_ready=0 and the index is not captured; the request is accepted at the first RUN cycle, and a second sequence to design 7 follows.
REQ-031 Mid-switch reset: rst pulsed one cycle during HOLD of a switch to design 3 -> sel_out=0, state HOLD; RUN on design 0 after R cycles.
REQ-032 User reset: in RUN, user_rst_n=0 for 2 cycles -> rst_n_out=0 for 2 cycles delayed by one; sel_out unchanged.
REQ-033 With DSC_RANGE_CHECK_EN and NUM_DESIGNS=20, req_sel=25 accepted -> err high for one cycle; sel_out, rst_n_out and active unchanged.

Source files
------------

// File: rtl/design_sel_ctrl_if.sv
// Design-switch request channel: the requester (master) offers an index, the selector (slave) accepts it.
interface design_sel_ctrl_if #(
    parameter int SEL_BITS = 5
);
    logic                req_valid;
    logic [SEL_BITS-1:0] req_sel;
    logic                req_ready;

    modport master (output req_valid, output req_sel, input  req_ready);
    modport slave  (input  req_valid, input  req_sel, output req_ready);
endinterface

// File: rtl/design_sel_ctrl.sv
// Design selector: sequences DRAIN -> SWITCH -> HOLD -> RUN around every change of the mux sel.
// Optional macro DSC_RANGE_CHECK_EN adds an err pulse and drops requests with an out-of-range index.
module design_sel_ctrl #(
    parameter int SEL_BITS    = 5,
    parameter int NUM_DESIGNS = 32,
    parameter int RST_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst,
    design_sel_ctrl_if.slave    req,
    input  logic                user_rst_n,
    output logic [SEL_BITS-1:0] sel_out,
    output logic                rst_n_out,
    output logic                active
`ifdef DSC_RANGE_CHECK_EN
    ,
    output logic                err
`endif
);

    typedef enum logic [1:0] {S_DRAIN, S_SWITCH, S_HOLD, S_RUN} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(RST_CYCLES);

    state_t              state, state_nx;
    logic [7:0]          cnt, cnt_nx;
    logic [SEL_BITS-1:0] pend_sel, pend_nx;
    logic [SEL_BITS-1:0] sel_nx;
    logic                accept;
`ifdef DSC_RANGE_CHECK_EN
    logic                err_nx;
`endif

    assign accept = req.req_valid && req.req_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend_sel;
        sel_nx   = sel_out;
`ifdef DSC_RANGE_CHECK_EN
        err_nx   = 1'b0;
`endif
        case (state)
            S_RUN: begin
                if (accept) begin
`ifdef DSC_RANGE_CHECK_EN
                    if (int'(req.req_sel) >= NUM_DESIGNS) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = S_DRAIN;
                        cnt_nx   = CNT_LOAD;
                        pend_nx  = req.req_sel;
                    end
`else
                    state_nx = S_DRAIN;
                    cnt_nx   = CNT_LOAD;
                    pend_nx  = req.req_sel;
`endif
                end
            end
            // Phase ends on the cycle the counter would reach zero; <=1 keeps a stray 0 from wrapping.
            S_DRAIN: begin
                if (cnt <= 8'd1) begin
                    state_nx = S_SWITCH;
                    cnt_nx   = 8'd0;
                    sel_nx   = pend_sel;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_SWITCH: begin
                state_nx = S_HOLD;
                cnt_nx   = CNT_LOAD;
            end
            S_HOLD: begin
                if (cnt <= 8'd1) begin
                    state_nx = S_RUN;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = S_HOLD;
                cnt_nx   = CNT_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_HOLD;
            cnt           <= CNT_LOAD;
            pend_sel      <= '0;
            sel_out       <= '0;
            rst_n_out     <= 1'b0;
            active        <= 1'b0;
            req.req_ready <= 1'b0;
`ifdef DSC_RANGE_CHECK_EN
            err           <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pend_sel      <= pend_nx;
            sel_out       <= sel_nx;
            rst_n_out     <= (state_nx == S_RUN) ? user_rst_n : 1'b0;
            active        <= (state_nx == S_RUN);
            req.req_ready <= (state_nx == S_RUN);
`ifdef DSC_RANGE_CHECK_EN
            err           <= err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_design_sel_ctrl.sv
// Bench for design_sel_ctrl: directed vector table, hand-written corner sequences and
// random traffic, all checked against a timeline model of the switch sequence.
module tb_design_sel_ctrl;
    localparam int R  = 4;
    localparam int ND = 20;
    localparam int SB = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          user_rst_n = 1'b1;
    logic [SB-1:0] sel_out;
    logic          rst_n_out, active, err;

    design_sel_ctrl_if #(.SEL_BITS(SB)) req_if ();

    design_sel_ctrl #(.SEL_BITS(SB), .NUM_DESIGNS(ND), .RST_CYCLES(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req_if),
        .user_rst_n (user_rst_n),
        .sel_out    (sel_out),
        .rst_n_out  (rst_n_out),
        .active     (active)
`ifdef DSC_RANGE_CHECK_EN
        ,
        .err        (err)
`endif
    );
`ifndef DSC_RANGE_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a switch accepted in cycle T takes the new sel at T+R+1 and resumes RUN at T+2R+2.
    int            cyc      = 0;
    int            run_at   = 1 << 30;
    int            sel_at   = 0;
    logic [SB-1:0] old_sel  = '0;
    logic [SB-1:0] new_sel  = '0;
    logic          urst_prev = 1'b1;
    logic          exp_err  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        bit            run_now;
        bit            exp_run;
        logic [SB-1:0] sel_now;
        run_now = (cyc >= run_at);
        sel_now = (cyc >= sel_at) ? new_sel : old_sel;
        exp_err = 1'b0;
        if (rst) begin
            old_sel = '0; new_sel = '0;
            sel_at  = cyc + 1;
            run_at  = cyc + 1 + R;
        end else if (run_now && req_if.req_valid) begin
`ifdef DSC_RANGE_CHECK_EN
            if (int'(req_if.req_sel) >= ND) exp_err = 1'b1;
            else begin
                old_sel = sel_now; new_sel = req_if.req_sel;
                sel_at  = cyc + 1 + R;
                run_at  = cyc + 2 * R + 2;
            end
`else
            old_sel = sel_now; new_sel = req_if.req_sel;
            sel_at  = cyc + 1 + R;
            run_at  = cyc + 2 * R + 2;
`endif
        end
        urst_prev = user_rst_n;
        @(posedge clk);
        #1;
        cyc++;
        exp_run = (cyc >= run_at);
        chk("m_sel",    int'(sel_out), int'((cyc >= sel_at) ? new_sel : old_sel));
        chk("m_rst_n",  int'(rst_n_out), exp_run ? int'(urst_prev) : 0);
        chk("m_active", int'(active), int'(exp_run));
        chk("m_ready",  int'(req_if.req_ready), int'(exp_run));
`ifdef DSC_RANGE_CHECK_EN
        chk("m_err",    int'(err), int'(exp_err));
`endif
    endtask

    task automatic wait_active(input string nm);
        int n;
        n = 0;
        while (!active && n < 40) begin
            tick();
            n++;
        end
        chk(nm, int'(active), 1);
    endtask

    typedef struct {
        bit            r;
        bit            v;
        logic [SB-1:0] s;
        bit            u;
        logic [SB-1:0] es;
        bit            ern;
        bit            ea;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(bit r, bit v, int s, bit u, int es, bit ern, bit ea);
        vec_t x;
        x.r = r; x.v = v; x.s = SB'(s); x.u = u; x.es = SB'(es); x.ern = ern; x.ea = ea;
        return x;
    endfunction

    initial begin
        req_if.req_valid = 1'b0;
        req_if.req_sel   = '0;

        // Reset for 3 cycles, RUN 4 cycles after release, switch to 5, then a 2-cycle user reset.
        for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 0, 1, 0, 0, 0);
        for (int i = 3; i < 6; i++) tbl[i] = mk(0, 0, 0, 1, 0, 0, 0);
        tbl[6] = mk(0, 0, 0, 1, 0, 1, 1);
        tbl[7] = mk(0, 1, 5, 1, 0, 0, 0);
        for (int i = 8; i < 11; i++)  tbl[i] = mk(0, 0, 0, 1, 0, 0, 0);
        for (int i = 11; i < 16; i++) tbl[i] = mk(0, 0, 0, 1, 5, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 5, 1, 1);
        tbl[17] = mk(0, 0, 0, 0, 5, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 5, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 5, 1, 1);
        tbl[20] = mk(0, 0, 0, 1, 5, 1, 1);

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].r; req_if.req_valid = tbl[i].v; req_if.req_sel = tbl[i].s;
            user_rst_n = tbl[i].u;
            tick();
            chk("t_sel",    int'(sel_out), int'(tbl[i].es));
            chk("t_rst_n",  int'(rst_n_out), int'(tbl[i].ern));
            chk("t_active", int'(active), int'(tbl[i].ea));
        end
        req_if.req_valid = 1'b0;

        // Backpressure: request 7 held through a switch to 2 is taken only once RUN returns.
        req_if.req_valid = 1'b1; req_if.req_sel = 5'd2;
        tick();
        req_if.req_sel = 5'd7;
        begin
            int n;
            n = 0;
            while (!req_if.req_ready && n < 40) begin
                chk("bp_not7", int'(sel_out == 5'd7), 0);
                tick();
                n++;
            end
        end
        chk("bp_ready", int'(req_if.req_ready), 1);
        chk("bp_sel2", int'(sel_out), 2);
        tick();
        req_if.req_valid = 1'b0;
        chk("bp_drain", int'(req_if.req_ready), 0);
        wait_active("bp_run");
        chk("bp_sel7", int'(sel_out), 7);

        // Mid-switch reset during HOLD of a switch to 3.
        req_if.req_valid = 1'b1; req_if.req_sel = 5'd3;
        tick();
        req_if.req_valid = 1'b0;
        for (int i = 0; i < R + 1; i++) tick();
        chk("mr_sel3", int'(sel_out), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_sel0", int'(sel_out), 0);
        for (int i = 0; i < R - 1; i++) tick();
        chk("mr_notrun", int'(active), 0);
        tick();
        chk("mr_run", int'(active), 1);
        chk("mr_run_sel", int'(sel_out), 0);

        // Out-of-range index.
        req_if.req_valid = 1'b1; req_if.req_sel = 5'd25;
        tick();
        req_if.req_valid = 1'b0;
`ifdef DSC_RANGE_CHECK_EN
        chk("or_err", int'(err), 1);
        chk("or_sel", int'(sel_out), 0);
        chk("or_active", int'(active), 1);
        tick();
        chk("or_err_clr", int'(err), 0);
`else
        chk("or_drain", int'(active), 0);
        wait_active("or_run");
        chk("or_sel25", int'(sel_out), 25);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst              = ($urandom_range(0, 49) == 0);
            req_if.req_valid = ($urandom_range(0, 3) == 0);
            req_if.req_sel   = SB'($urandom_range(0, 31));
            user_rst_n       = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
